// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared types and constants for the mux4 select-line scan controller.
// Imported by rr_next_chan and mux4_scan_ctrl.
package mux4_scan_pkg;

    localparam int unsigned NUM_CHAN = 4;

    typedef logic [1:0] chan_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scan_state_t;

    // Highest-numbered set bit of the enable mask; callers must qualify with en != 0.
    function automatic chan_t highest_chan(input logic [NUM_CHAN-1:0] en);
        chan_t hi;
        hi = '0;
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            if (en[i]) begin
                hi = chan_t'(i);
            end
        end
        return hi;
    endfunction

endpackage

// File: rtl/mux4_scan_ctrl_rr_next_chan.sv
// Round-robin channel picker: first enabled channel strictly after ptr_i,
// wrapping 3->0; falls back to ptr_i itself when it is the only one enabled.
module rr_next_chan
    import mux4_scan_pkg::*;
(
    input  chan_t               ptr_i,
    input  logic [NUM_CHAN-1:0] en_i,
    output chan_t               next_o,
    output logic                none_o
);

    chan_t cand;
    logic  found;

    always_comb begin
        next_o = ptr_i;
        none_o = (en_i == '0);
        found  = 1'b0;
        cand   = ptr_i;
        for (int unsigned k = 1; k <= NUM_CHAN; k++) begin
            cand = ptr_i + chan_t'(k);
            if (!found && en_i[cand]) begin
                next_o = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Select-line sequencer for a mux4x1: round-robin scan with dwell, capture and
// valid/ready hand-off. Define MUX4_SCAN_FRAME_EN to build the frame assembler.
module mux4_scan_ctrl
    import mux4_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NUM_CHAN-1:0] chan_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out,
    output logic               s0,
    output logic               s1,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               sample_data,
    output logic [1:0]         sample_chan,
    output logic               busy,
    output logic [NUM_CHAN-1:0] frame,
    output logic               frame_valid
);

    scan_state_t        state_q, state_d;
    chan_t              sel_q, sel_d;
    chan_t              ptr_q, ptr_d;
    chan_t              chan_q, chan_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               data_q, data_d;
    logic               stop_seen_q, stop_seen_d;
    logic               busy_q;

    logic [DWELL_W-1:0] dwell_eff;
    chan_t              rr_ptr;
    chan_t              rr_next;
    logic               rr_none;
    logic               handshake;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign handshake = (state_q == HOLD) && sample_ready;

    // On the handshake edge the pointer is about to become chan_q, so pick from there.
    assign rr_ptr = (state_q == HOLD) ? chan_q : ptr_q;

    rr_next_chan u_rr (
        .ptr_i  (rr_ptr),
        .en_i   (chan_en),
        .next_o (rr_next),
        .none_o (rr_none)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        chan_d      = chan_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        data_d      = data_q;
        stop_seen_d = stop_seen_q;

        unique case (state_q)
            IDLE: begin
                if (!stop && start && !rr_none) begin
                    sel_d   = rr_next;
                    cnt_d   = dwell_eff;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == DWELL_W'(1)) begin
                    valid_d = 1'b1;
                    data_d  = mux_out;
                    chan_d  = sel_q;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            HOLD: begin
                stop_seen_d = stop_seen_q | stop;
                if (handshake) begin
                    valid_d     = 1'b0;
                    ptr_d       = chan_q;
                    stop_seen_d = 1'b0;
                    if (stop_seen_q || stop || rr_none) begin
                        state_d = IDLE;
                    end else begin
                        sel_d   = rr_next;
                        cnt_d   = dwell_eff;
                        state_d = SETTLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= chan_t'(NUM_CHAN - 1);
            chan_q      <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            data_q      <= 1'b0;
            stop_seen_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            chan_q      <= chan_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            stop_seen_q <= stop_seen_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign {s1, s0}     = sel_q;
    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign sample_chan  = chan_q;
    assign busy         = busy_q;

`ifdef MUX4_SCAN_FRAME_EN
    logic [NUM_CHAN-1:0] frame_q;
    logic                frame_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            if (handshake) begin
                frame_q[chan_q] <= data_q;
            end
            frame_valid_q <= handshake && (chan_en != '0) && (chan_q == highest_chan(chan_en));
        end
    end

    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
`else
    assign frame       = '0;
    assign frame_valid = 1'b0;
`endif

endmodule
